// File: rtl/pattern_playback.sv
// pattern_playback
//   Receives a pattern over a UART line, stores BUF_BYTES bytes in an internal
//   buffer, then replays the stored bits on o_pattern_out. Bits go out LSB first,
//   one bit every SAMPLE_DIV clocks.
//
// Parameters
//   CLKS_PER_BIT   system clocks per UART bit (expected to be at least 2)
//   CLK_HZ         system clock frequency
//   SAMPLING_RATE  playback bits per second (SAMPLE_DIV = CLK_HZ/SAMPLING_RATE)
//   BUF_BYTES      bytes loaded per pattern, 1..1024
//
// Ports
//   i_sys_clk      system clock; all logic runs on its rising edge
//   i_rst_n        synchronous active-low reset
//   i_Rx_Serial    UART receive line (8N1, LSB first, idle high)
//   start          level enable: 1 runs load/play, 0 aborts to IDLE
//   o_pattern_out  replayed probe bit
//   o_loading      high while loading the buffer
//   o_playing      high while replaying the buffer
//   o_done         one-cycle pulse when a playback completes
//   o_rx_err       one-cycle pulse on a UART framing error
//   o_byte_count   bytes stored during the current load
module pattern_playback #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int CLK_HZ        = 50000000,
  parameter int SAMPLING_RATE = 1000000,
  parameter int BUF_BYTES     = 1024
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_n,
  input  logic        i_Rx_Serial,
  input  logic        start,
  output logic        o_pattern_out,
  output logic        o_loading,
  output logic        o_playing,
  output logic        o_done,
  output logic        o_rx_err,
  output logic [10:0] o_byte_count
);

  localparam int SAMPLE_DIV = CLK_HZ / SAMPLING_RATE;
  localparam int AW = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [10:0]   BUF_FULL  = 11'(BUF_BYTES);
  localparam logic [10:0]   BYTE_LAST = 11'(BUF_BYTES - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(BUF_BYTES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_e;

  // UART receiver state
  rx_state_e      rxState_q, rxState_d;
  logic           rxMeta_q, rxSync_q, rxPrev_q;
  logic [CW-1:0]  rxClk_q, rxClk_d;
  logic [2:0]     rxBit_q, rxBit_d;
  logic [7:0]     rxShift_q, rxShift_d;
  logic           rxValid_q, rxValid_d;
  logic           rxErr_q, rxErr_d;

  // Main sequencer and playback datapath
  state_e         state_q, state_d;
  logic [10:0]    byteCount_q;
  logic [AW-1:0]  rdAddr_q;
  logic [AW-1:0]  rdAddrNext;
  logic [10:0]    byteIdx_q;
  logic [2:0]     bitIdx_q;
  logic [DW-1:0]  divCnt_q;
  logic [7:0]     shift_q;
  logic           playRun_q;
  logic           fill_q;
  logic           playLast;
  logic           memWe;

  logic [7:0]     mem [0:BUF_BYTES-1];
  logic [7:0]     rdData_q;

  // The serial line is asynchronous, so it goes through two flops before any
  // logic sees it. A third flop holds the previous synchronized value for
  // start-bit edge detection. All three reset to the idle (high) level, so
  // leaving reset never looks like a falling edge.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= i_Rx_Serial;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // UART receiver state register. rxValid_q and rxErr_q are single-cycle
  // strobes. rxShift_q holds the received byte while rxValid_q is high.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      rxState_q <= RX_IDLE;
      rxClk_q   <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
      rxValid_q <= 1'b0;
      rxErr_q   <= 1'b0;
    end else begin
      rxState_q <= rxState_d;
      rxClk_q   <= rxClk_d;
      rxBit_q   <= rxBit_d;
      rxShift_q <= rxShift_d;
      rxValid_q <= rxValid_d;
      rxErr_q   <= rxErr_d;
    end
  end

  // UART receiver next-state logic. The start bit is checked halfway through
  // its period, so a short low glitch falls back to idle quietly. After that
  // check, every sample lands one full bit period later, near mid-bit. Data
  // shifts in from the top, so the first bit received ends up in bit 0.
  always_comb begin
    rxState_d = rxState_q;
    rxClk_d   = rxClk_q;
    rxBit_d   = rxBit_q;
    rxShift_d = rxShift_q;
    rxValid_d = 1'b0;
    rxErr_d   = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        rxClk_d = '0;
        rxBit_d = '0;
        if (rxPrev_q && !rxSync_q) begin
          rxState_d = RX_START;
        end
      end
      RX_START: begin
        if (rxClk_q == HALF_LAST) begin
          rxClk_d   = '0;
          rxState_d = rxSync_q ? RX_IDLE : RX_DATA;
        end else begin
          rxClk_d = rxClk_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rxClk_q == BIT_LAST) begin
          rxClk_d   = '0;
          rxShift_d = {rxSync_q, rxShift_q[7:1]};
          if (rxBit_q == 3'd7) begin
            rxState_d = RX_STOP;
          end else begin
            rxBit_d = rxBit_q + 3'd1;
          end
        end else begin
          rxClk_d = rxClk_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rxClk_q == BIT_LAST) begin
          rxClk_d   = '0;
          rxState_d = RX_IDLE;
          if (rxSync_q) begin
            rxValid_d = 1'b1;
          end else begin
            rxErr_d = 1'b1;
          end
        end else begin
          rxClk_d = rxClk_q + 1'b1;
        end
      end
      default: begin
        rxState_d = RX_IDLE;
      end
    endcase
  end

  // A received byte is stored only while loading and only while the buffer
  // still has room. Bytes that arrive in any other state are dropped.
  assign memWe = i_rst_n && (state_q == LOAD) && start && rxValid_q &&
                 (byteCount_q != BUF_FULL);

  // playLast marks the final clock of the final bit of the final byte.
  assign playLast = playRun_q && (divCnt_q == DIV_LAST) && (bitIdx_q == 3'd7) &&
                    (byteIdx_q == BYTE_LAST);

  assign rdAddrNext = (rdAddr_q == ADDR_LAST) ? '0 : rdAddr_q + 1'b1;

  // Main sequencer state register
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Main sequencer next-state logic. Dropping start aborts LOAD or PLAY
  // without passing through DONE, so an aborted run never pulses o_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (!start) begin
          state_d = IDLE;
        end else if (byteCount_q == BUF_FULL) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (!start) begin
          state_d = IDLE;
        end else if (playLast) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Buffer memory: one write port fed by the receiver and one registered read
  // port. The read port samples rdAddr_q on every clock, so the next byte is
  // always waiting in rdData_q when the shifter needs it.
  always_ff @(posedge i_sys_clk) begin
    if (memWe) begin
      mem[byteCount_q[AW-1:0]] <= rxShift_q;
    end
    rdData_q <= mem[rdAddr_q];
  end

  // Byte counter and playback datapath.
  // The byte counter is also the write pointer. It clears on LOAD entry and
  // otherwise holds, so the last count stays visible after the load ends.
  // Playback takes two cycles to fill: the first clock in PLAY reads byte 0,
  // and the second loads it into the shifter. From then on, each bit holds
  // for SAMPLE_DIV clocks. At the end of bit 7, the prefetched next byte loads
  // straight in, so there is no gap between bytes. Any exit from PLAY, normal
  // or aborted, clears the playback registers.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      byteCount_q <= '0;
      rdAddr_q    <= '0;
      byteIdx_q   <= '0;
      bitIdx_q    <= '0;
      divCnt_q    <= '0;
      shift_q     <= '0;
      playRun_q   <= 1'b0;
      fill_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && state_d == LOAD) begin
        byteCount_q <= '0;
      end else if (memWe) begin
        byteCount_q <= byteCount_q + 11'd1;
      end

      if (state_q != PLAY || state_d != PLAY) begin
        rdAddr_q  <= '0;
        byteIdx_q <= '0;
        bitIdx_q  <= '0;
        divCnt_q  <= '0;
        shift_q   <= '0;
        playRun_q <= 1'b0;
        fill_q    <= 1'b0;
      end else if (!playRun_q) begin
        if (!fill_q) begin
          fill_q <= 1'b1;
        end else begin
          shift_q   <= rdData_q;
          playRun_q <= 1'b1;
          divCnt_q  <= '0;
          bitIdx_q  <= '0;
          byteIdx_q <= '0;
          rdAddr_q  <= rdAddrNext;
        end
      end else if (divCnt_q == DIV_LAST) begin
        divCnt_q <= '0;
        if (bitIdx_q == 3'd7) begin
          shift_q   <= rdData_q;
          bitIdx_q  <= '0;
          byteIdx_q <= byteIdx_q + 11'd1;
          rdAddr_q  <= rdAddrNext;
        end else begin
          shift_q  <= {1'b0, shift_q[7:1]};
          bitIdx_q <= bitIdx_q + 3'd1;
        end
      end else begin
        divCnt_q <= divCnt_q + 1'b1;
      end
    end
  end

  assign o_pattern_out = playRun_q & shift_q[0];
  assign o_loading     = (state_q == LOAD);
  assign o_playing     = (state_q == PLAY);
  assign o_done        = (state_q == DONE);
  assign o_rx_err      = rxErr_q;
  assign o_byte_count  = byteCount_q;

endmodule

// File: tb/tb_pattern_playback.sv
// tb_pattern_playback
//   Directed testbench for pattern_playback. It uses CLKS_PER_BIT=4,
//   SAMPLE_DIV=5 and BUF_BYTES=4. The bench sends the bytes A5 01 FF 00 over
//   the UART line and compares the replayed bit stream with a list of bits
//   built here from those bytes. It also covers reset, glitches, framing
//   errors, bytes that arrive during playback, aborts and reset in mid-byte.
`timescale 1ns/1ps
module tb_pattern_playback;

  localparam int CLK_PERIOD = 10;

  logic        clk;
  logic        rstN;
  logic        rxLine;
  logic        startIn;
  logic        patternOut;
  logic        loading;
  logic        playing;
  logic        done;
  logic        rxErr;
  logic [10:0] byteCount;

  int total;
  int bad;
  int doneCount;
  int errCount;
  logic playLog[$];
  logic [7:0] patternBytes [4];

  pattern_playback #(
    .CLKS_PER_BIT (4),
    .CLK_HZ       (50000000),
    .SAMPLING_RATE(10000000),
    .BUF_BYTES    (4)
  ) dut (
    .i_sys_clk    (clk),
    .i_rst_n      (rstN),
    .i_Rx_Serial  (rxLine),
    .start        (startIn),
    .o_pattern_out(patternOut),
    .o_loading    (loading),
    .o_playing    (playing),
    .o_done       (done),
    .o_rx_err     (rxErr),
    .o_byte_count (byteCount)
  );

  initial clk = 1'b0;
  always #(CLK_PERIOD / 2) clk = ~clk;

  // Background monitor. It counts done and framing-error pulses, one count per
  // high cycle. It also logs the output bit on every cycle spent in PLAY.
  always @(negedge clk) begin
    if (done) doneCount++;
    if (rxErr) errCount++;
    if (playing) playLog.push_back(patternOut);
  end

  // Runaway guard
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one 8N1 frame, 4 clocks per bit, and then 2 idle clocks.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    rxLine = 1'b0;
    waitCycles(4);
    for (int i = 0; i < 8; i++) begin
      rxLine = data[i];
      waitCycles(4);
    end
    rxLine = stopBit;
    waitCycles(4);
    rxLine = 1'b1;
    waitCycles(2);
  endtask

  // Loads the four pattern bytes, optionally sends a stray byte during PLAY,
  // then checks the bit stream, the done pulse and the automatic reload.
  task automatic runPlayback(input bit inject);
    int doneBefore;
    bit seen;
    bit doneSeen;
    longint tPlay;
    longint tDone;
    int mism;
    logic expStream[$];

    doneBefore = doneCount;
    playLog.delete();
    seen = 1'b0;
    doneSeen = 1'b0;
    tPlay = 0;
    tDone = 0;

    for (int k = 0; k < 4; k++) begin
      applyStimulus(patternBytes[k], 1'b1);
      @(negedge clk);
      checkOutput("byte_count", byteCount, k + 1);
    end

    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (playing) begin
        seen = 1'b1;
        tPlay = $time;
      end
    end
    checkOutput("playing_rise", seen, 1);

    if (inject) begin
      repeat (10) @(negedge clk);
      applyStimulus(8'h77, 1'b1);
    end

    for (int i = 0; i < 400 && !doneSeen; i++) begin
      @(negedge clk);
      if (done) begin
        doneSeen = 1'b1;
        tDone = $time;
      end
    end
    checkOutput("done_seen", doneSeen, 1);
    // The first bit appears 2 cycles after PLAY entry, and 32 bits x 5 cycles
    // later o_done rises: 162 cycles after entry.
    checkOutput("done_latency", 32'((tDone - tPlay) / CLK_PERIOD), 162);
    checkOutput("pattern_in_done", patternOut, 0);
    checkOutput("count_hold_done", byteCount, 4);

    @(negedge clk);
    checkOutput("idle_after_done", {loading, playing, patternOut}, 3'b000);
    @(negedge clk);
    checkOutput("reload_loading", loading, 1);
    checkOutput("reload_count", byteCount, 0);

    repeat (3) @(negedge clk);
    checkOutput("done_pulses", doneCount - doneBefore, 1);

    expStream.push_back(1'b0);
    expStream.push_back(1'b0);
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        repeat (5) expStream.push_back(patternBytes[b][i]);
      end
    end
    checkOutput("stream_len", playLog.size(), expStream.size());
    mism = 0;
    for (int i = 0; i < expStream.size(); i++) begin
      if (i >= playLog.size() || playLog[i] !== expStream[i]) mism++;
    end
    checkOutput("stream_bits", mism, 0);
  endtask

  initial begin
    int errBefore;
    int doneBefore;
    bit seen;

    total = 0;
    bad = 0;
    doneCount = 0;
    errCount = 0;
    patternBytes[0] = 8'hA5;
    patternBytes[1] = 8'h01;
    patternBytes[2] = 8'hFF;
    patternBytes[3] = 8'h00;

    // Reset held for two cycles while start is already high
    rstN = 1'b0;
    startIn = 1'b1;
    rxLine = 1'b1;
    @(negedge clk);
    checkOutput("reset_outputs", {patternOut, loading, playing, done, rxErr, byteCount}, 0);
    @(negedge clk);
    checkOutput("reset_no_load", {patternOut, loading, playing, done, rxErr, byteCount}, 0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("load_after_reset", loading, 1);
    checkOutput("load_entry_count", byteCount, 0);
    waitCycles(1);

    // One-cycle low glitch: the start-bit check rejects it
    rxLine = 1'b0;
    waitCycles(1);
    rxLine = 1'b1;
    waitCycles(20);
    @(negedge clk);
    checkOutput("glitch_count", byteCount, 0);
    checkOutput("glitch_err", errCount, 0);

    // Framing error: the stop bit is low
    applyStimulus(8'h3C, 1'b0);
    waitCycles(3);
    @(negedge clk);
    checkOutput("frame_err_pulse", errCount, 1);
    checkOutput("frame_err_count", byteCount, 0);

    // Normal load and playback, then a run with a stray byte during PLAY
    runPlayback(1'b0);
    runPlayback(1'b1);

    // Abort 20 cycles into PLAY
    doneBefore = doneCount;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(patternBytes[k], 1'b1);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (playing) seen = 1'b1;
    end
    checkOutput("abort_play_seen", seen, 1);
    repeat (20) @(negedge clk);
    checkOutput("abort_still_play", playing, 1);
    startIn = 1'b0;
    @(negedge clk);
    checkOutput("abort_playing", playing, 0);
    checkOutput("abort_pattern", patternOut, 0);
    checkOutput("abort_count_hold", byteCount, 4);
    repeat (10) @(negedge clk);
    checkOutput("abort_idle", {loading, playing, patternOut}, 3'b000);
    checkOutput("abort_no_done", doneCount - doneBefore, 0);
    startIn = 1'b1;
    @(negedge clk);
    checkOutput("restart_loading", loading, 1);
    checkOutput("restart_count", byteCount, 0);

    // Reset in the middle of a byte: no byte stored, no error pulse
    errBefore = errCount;
    doneBefore = doneCount;
    rxLine = 1'b0;
    repeat (12) @(negedge clk);
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midbyte_reset_outputs",
                {patternOut, loading, playing, done, rxErr, byteCount}, 0);
    rxLine = 1'b1;
    rstN = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("midbyte_no_err", errCount - errBefore, 0);
    checkOutput("midbyte_no_done", doneCount - doneBefore, 0);
    checkOutput("midbyte_count", byteCount, 0);
    checkOutput("midbyte_loading", loading, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_playback.md
PATTERN_PLAYBACK -- requirements
Module: pattern_playback

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, system clocks per UART bit.
REQ-002 Parameter CLK_HZ, default 50000000, system clock frequency.
REQ-003 Parameter SAMPLING_RATE, default 1000000, playback bits per second; SAMPLE_DIV = CLK_HZ/SAMPLING_RATE clocks per output bit.
REQ-004 Parameter BUF_BYTES, default 1024, bytes loaded per pattern, range 1..1024.
REQ-005 One clock and one reset; the reset is synchronous and active-low.
REQ-006 i_sys_clk  in  1  system clock; all logic on its rising edge.
REQ-007 i_rst_n  in  1  synchronous active-low reset.
REQ-008 i_Rx_Serial  in  1  UART receive line: 8N1, LSB first, idle high.
REQ-009 start  in  1  level enable; 1 = run the load/play sequence, 0 = abort to IDLE.
REQ-010 o_pattern_out  out  1  replayed probe bit.
REQ-011 o_loading  out  1  high while in LOAD.
REQ-012 o_playing  out  1  high while in PLAY.
REQ-013 o_done  out  1  one-cycle pulse when playback completes.
REQ-014 o_rx_err  out  1  one-cycle pulse on a UART framing error.
REQ-015 o_byte_count  out  11  bytes stored in the current LOAD.

Function
REQ-016 i_Rx_Serial shall pass through a 2-flop synchronizer; both flops reset to 1.
REQ-017 RX FSM states RX_IDLE, RX_START, RX_DATA, RX_STOP; a synchronized falling edge in RX_IDLE enters RX_START.
REQ-018 RX_START shall sample at CLKS_PER_BIT/2; if the line is high it returns to RX_IDLE with no byte and no error, otherwise it enters RX_DATA.
REQ-019 RX_DATA shall sample 8 bits, one every CLKS_PER_BIT clocks, bit 0 first.
REQ-020 RX_STOP shall sample after CLKS_PER_BIT: 1 = byte valid for one cycle; 0 = byte discarded and o_rx_err pulses one cycle; either way it returns to RX_IDLE.
REQ-021 Main FSM states IDLE, LOAD, PLAY, DONE; reset state IDLE.
REQ-022 IDLE->LOAD when start=1; on entry wr_ptr=0 and o_byte_count=0.
REQ-023 LOAD: each valid RX byte shall be written to internal memory at wr_ptr, then wr_ptr and o_byte_count increment by 1.
REQ-024 LOAD->PLAY on the cycle after the write that makes o_byte_count equal BUF_BYTES.
REQ-025 Memory: BUF_BYTES x 8, synchronous read with 1-cycle latency, no reset of contents.
REQ-026 PLAY: byte 0 shall be fetched on entry and loaded into the shift register 2 cycles after entry; o_pattern_out shall take bit 0 at that time.
REQ-027 Each bit shall be held exactly SAMPLE_DIV cycles, bits 0..7 of each byte in order, bytes 0..BUF_BYTES-1 in order, with no gap between bytes (next byte prefetched).
REQ-028 After the last bit's SAMPLE_DIV period: PLAY->DONE; DONE asserts o_done for one cycle and then goes to IDLE; if start is still 1, IDLE re-enters LOAD on the following cycle.
REQ-029 RX bytes arriving in IDLE, PLAY or DONE shall be discarded; framing errors still pulse o_rx_err.
REQ-030 start=0 in LOAD or PLAY: next cycle IDLE, o_pattern_out=0, pointers cleared, no o_done.
REQ-031 o_pattern_out shall be 0 in IDLE, LOAD and DONE.
REQ-032 o_byte_count shall hold its value through PLAY, DONE and IDLE until the next LOAD entry.

Reset
REQ-033 With i_rst_n=0 at a clock edge: main FSM IDLE, RX FSM RX_IDLE, all counters and pointers 0, synchronizer flops 1.
REQ-034 Reset outputs: o_pattern_out=0, o_loading=0, o_playing=0, o_done=0, o_rx_err=0, o_byte_count=0.
REQ-035 Reset mid-byte or mid-playback shall abandon the operation with no o_done or o_rx_err pulse.

Verification (bench parameters: CLKS_PER_BIT=4, CLK_HZ=50000000, SAMPLING_RATE=10000000 so SAMPLE_DIV=5, BUF_BYTES=4)
REQ-036 Hold i_rst_n=0 for 2 cycles with start=1 -> all outputs 0; LOAD entered only after i_rst_n=1.
REQ-037 start=1, send 0xA5, 0x01, 0xFF, 0x00 -> o_byte_count 1,2,3,4; o_playing rises; o_pattern_out = 1,0,1,0,0,1,0,1, 1,0,0,0,0,0,0,0, 1x8, 0x8, each bit held 5 cycles; o_done pulses exactly once, 160 cycles after the first bit.
REQ-038 Send 0x3C with stop bit 0 during LOAD -> o_rx_err pulses 1 cycle; o_byte_count unchanged.
REQ-039 Drive i_Rx_Serial low for 1 cycle -> no byte stored, no o_rx_err.
REQ-040 Drop start 20 cycles into PLAY -> next cycle o_playing=0, o_pattern_out=0, no o_done; reassert start -> o_loading=1, o_byte_count=0.
REQ-041 Send 0x77 during PLAY -> ignored; playback bit stream identical to REQ-037.
